// File: rtl/i2c_codec_responder.sv
// I2C write-only target modelling the audio-codec end of the av_config link.
// Decodes {dev_addr, {reg[6:0], d8}, data[7:0]} and commits 9-bit values into a local shadow.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NUM_REGS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic                        wr_valid,
  output logic [6:0]                  wr_addr,
  output logic [8:0]                  wr_data,
  output logic                        addr_err,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [8:0]                  rd_data,
  output logic                        busy
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_BYTE1, ST_ACK1, ST_BYTE2, ST_ACK2, ST_IGNORE
  } state_e;

  // Synchronizer and history flops reset to 1 so an idle bus never looks like START.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic [1:0] scl_hist_q, sda_hist_q;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] reg_q, reg_d;
  logic       d8_q, d8_d;
  logic [7:0] byte2_q, byte2_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q;
  logic       commit;

  logic       wr_valid_q, addr_err_q;
  logic [6:0] wr_addr_q;
  logic [8:0] wr_data_q, rd_data_q;
  logic [8:0] regs_q [NUM_REGS];

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det, in_range;

  assign scl_rise  =  scl_hist_q[0] & ~scl_hist_q[1];
  assign scl_fall  = ~scl_hist_q[0] &  scl_hist_q[1];
  assign sda_rise  =  sda_hist_q[0] & ~sda_hist_q[1];
  assign sda_fall  = ~sda_hist_q[0] &  sda_hist_q[1];
  assign start_det =  scl_hist_q[0] &  scl_hist_q[1] & sda_fall;
  assign stop_det  =  scl_hist_q[0] &  scl_hist_q[1] & sda_rise;
  assign in_range  = ({1'b0, reg_q} < 8'(NUM_REGS));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      reg_q      <= '0;
      d8_q       <= 1'b0;
      byte2_q    <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      reg_q      <= reg_d;
      d8_q       <= d8_d;
      byte2_q    <= byte2_d;
      sda_oe_q   <= sda_oe_d;
      if (stop_det)       busy_q <= 1'b0;
      else if (start_det) busy_q <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    reg_d    = reg_q;
    d8_d     = d8_q;
    byte2_d  = byte2_q;
    sda_oe_d = sda_oe_q;
    commit   = 1'b0;

    if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_BYTE1, ST_BYTE2: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_hist_q[0]};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            // 8th SCL fall: decide the byte and, if accepted, start pulling SDA for ACK.
            cnt_d = '0;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                state_d  = ST_ACK_A;
                sda_oe_d = 1'b1;
              end else begin
                state_d  = ST_IGNORE;
              end
            end else if (state_q == ST_BYTE1) begin
              reg_d    = shift_q[7:1];
              d8_d     = shift_q[0];
              state_d  = ST_ACK1;
              sda_oe_d = 1'b1;
            end else begin
              byte2_d  = shift_q;
              state_d  = ST_ACK2;
              sda_oe_d = 1'b1;
            end
          end
        end
        ST_ACK_A, ST_ACK1, ST_ACK2: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            case (state_q)
              ST_ACK_A: state_d = ST_BYTE1;
              ST_ACK1:  state_d = ST_BYTE2;
              default: begin
                state_d = ST_IGNORE;
                commit  = 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the register file is reset explicitly because the shadow must read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_valid_q <= commit & in_range;
      addr_err_q <= commit & ~in_range;
      rd_data_q  <= regs_q[rd_addr];
      if (commit && in_range) begin
        regs_q[reg_q[AW-1:0]] <= {d8_q, byte2_q};
        wr_addr_q             <= reg_q;
        wr_data_q             <= {d8_q, byte2_q};
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign addr_err = addr_err_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;

endmodule

// File: doc/i2c_codec_responder.md
# i2c_codec_responder

I2C target (responder) that models the audio-codec end of the av_config I2C link. It decodes the 3-byte codec write protocol: device address, {reg[6:0], data[8]}, data[7:0]. It ACKs matching transfers and commits 9-bit values into a local register file. The block sits beside the av_config master in the FPGA fabric, for loopback checking and for a codec-less configuration shadow. The HPS and Game Boy logic can read the shadow back.

## Interface
- DEV_ADDR, 7'h1A, 7-bit target address (write byte 8'h34)
- NUM_REGS, 16, register file depth; valid register addresses are 0..NUM_REGS-1
- clk  input  1  system clock; must be at least 16x the SCL frequency
- reset  input  1  synchronous, active-high
- scl_in  input  1  raw SCL from the pad; asynchronous
- sda_in  input  1  raw SDA from the pad; asynchronous
- sda_oe  output  1  1 = drive SDA low (open-drain); 0 = release
- wr_valid  output  1  one-cycle pulse when a register write commits
- wr_addr  output  7  register address of the last commit
- wr_data  output  9  data of the last commit
- addr_err  output  1  one-cycle pulse when a write targets an address >= NUM_REGS
- rd_addr  input  4  register file read address, log2(NUM_REGS) bits
- rd_data  output  9  registered read data
- busy  output  1  high from START until STOP

## Operation
- SCL/SDA pass through a 2-FF synchronizer, then a history register, which gives edge flags.
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- Both are detected in any state. STOP wins over a data edge in the same cycle.
- Bits are sampled MSB-first on SCL rising edges.
- SDA output changes only on SCL falling edges.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits. If bits[7:1]==DEV_ADDR and R/W=0, go to ACK_A; otherwise go to IGNORE and stay released (NACK).
  - ACK_A: assert sda_oe from the 8th SCL fall to the 9th SCL fall, then go to BYTE1.
  - BYTE1: shift 8 bits, latch reg[6:0]=b[7:1] and d8=b[0], then go to ACK1.
  - ACK1: ACK as in ACK_A, then go to BYTE2.
  - BYTE2: shift 8 bits, then go to ACK2.
  - ACK2: ACK, then commit at the 9th SCL fall and go to IGNORE.
  - IGNORE: keep SDA released and ignore all further bytes (they are NACKed) until STOP or START.
- START in any state, including a repeated start: clear the bit counter and go to ADDR. A partial transfer is discarded with no commit.
- STOP in any state: go to IDLE, set sda_oe=0, and discard any partial transfer.
- Commit when reg < NUM_REGS:
  - regfile[reg] <= {d8, byte2}
  - wr_addr/wr_data update
  - wr_valid=1 for one cycle
- Commit when reg >= NUM_REGS: addr_err=1 for one cycle, no regfile write, wr_addr/wr_data unchanged. The byte is still ACKed.
- Reads (R/W=1) are not supported and are NACKed via IGNORE.
- Reset values:
  - state IDLE
  - sda_oe=0, wr_valid=0, addr_err=0, busy=0
  - wr_addr=0, wr_data=0, rd_data=0
  - all regfile entries 0
- A reset mid-transfer aborts it; the block then waits for a fresh START.

## Timing
- Input latency is 3 clk from a pad edge to the edge flag: 2 synchronizer flops plus the history flop.
- sda_oe rises 1 clk after the detected 8th SCL fall of a byte. It falls 1 clk after the detected 9th SCL fall.
- wr_valid/addr_err fire 1 clk after the detected 9th SCL fall of byte 2. The regfile, wr_addr and wr_data are updated on the same edge on which wr_valid is seen high.
- rd_data = regfile[rd_addr], registered with 1-clk latency. A read of an address being written in the same cycle returns the old value.
- busy rises 1 clk after START is detected and falls 1 clk after STOP is detected.
- No clock stretching: SCL is never driven.

## Test plan
- Write 0x34, 0x0C, 0x9F, then STOP. Expect:
  - ACK on all 3 slots
  - wr_valid pulses once with wr_addr=7'h06, wr_data=9'h09F
  - rd_addr=6 then gives rd_data=9'h09F
- Address 0x36 (wrong device): expect no ACK (sda_oe stays 0 for the whole transfer), no wr_valid, busy drops after STOP.
- Address 0x35 (read request): expect NACK on the address slot, no commit, regfile unchanged.
- Write to reg 0x20 (bytes 0x34, 0x41, 0x23): expect ACKs, addr_err pulse, wr_valid stays 0, regfile unchanged.
- START, 0x34, 0x0C, then a repeated START, then 0x34, 0x12, 0x55, STOP. Expect:
  - the first transfer is discarded
  - a single commit with wr_addr=9, wr_data=9'h055
- Reset asserted mid-BYTE2, then a complete write 0x34, 0x02, 0x17. Expect:
  - sda_oe=0 immediately after reset
  - all regs read 0
  - the next full write commits wr_addr=1, wr_data=9'h017
